// File: rtl/dcache_pkg.sv
// dcache_pkg
// Shared definitions for the dcache controller: geometry, address slicing,
// tag-field layout, FSM state encoding and a line-address helper.
//
// Address layout: tag[31:9] | index[8:5] | word[4:2] | byte[1:0]
// SRAM tag field: {valid, dirty, tag[22:0]}
package dcache_pkg;

   localparam int ADDR_W  = 32;
   localparam int LINE_W  = 256;
   localparam int IDX_W   = 4;
   localparam int OFF_W   = 5;
   localparam int TAG_W   = ADDR_W - IDX_W - OFF_W;
   localparam int WORD_W  = 32;
   localparam int WSEL_W  = 3;
   localparam int TAGF_W  = TAG_W + 2;

   localparam int VALID_BIT = 24;
   localparam int DIRTY_BIT = 23;

   localparam int WORD_LO = 2;
   localparam int WORD_HI = 4;
   localparam int IDX_LO  = 5;
   localparam int IDX_HI  = 8;
   localparam int TAG_LO  = 9;
   localparam int TAG_HI  = 31;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_MISS       = 3'd1,
      ST_WRITEBACK  = 3'd2,
      ST_READMISS   = 3'd3,
      ST_READMISSOK = 3'd4
   } state_t;

   // Line-aligned memory address from a tag and set index.
   function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                   input logic [IDX_W-1:0] idx);
      return {tag, idx, {OFF_W{1'b0}}};
   endfunction

endpackage

// File: rtl/dcache_line_merge.sv
// dcache_line_merge
// Combinational word access into a cache line.
//   line_i : source line (8 x 32-bit words)
//   sel_i  : word index
//   word_i : word to insert at sel_i
//   word_o : word sel_i of line_i
//   line_o : line_i with word sel_i replaced by word_i
module dcache_line_merge
   import dcache_pkg::*;
(
   input  logic [LINE_W-1:0] line_i,
   input  logic [WSEL_W-1:0] sel_i,
   input  logic [WORD_W-1:0] word_i,
   output logic [WORD_W-1:0] word_o,
   output logic [LINE_W-1:0] line_o
);

   logic [7:0] bit_base;

   assign bit_base = {sel_i, 5'b00000};

   always_comb begin
      word_o = line_i[bit_base +: WORD_W];
      line_o = line_i;
      line_o[bit_base +: WORD_W] = word_i;
   end

endmodule

// File: rtl/dcache_controller.sv
// dcache_controller
// Initiator-side controller for a 2-way, 16-set dcache SRAM with 256-bit
// lines. Serves CPU loads/stores from the SRAM's combinational lookup and,
// on a miss, writes back a dirty victim, refills the line and stalls the
// CPU until the access re-looks up and hits.
//
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   cpu_addr_i/data_i       CPU byte address and store data
//   cpu_MemRead_i/Write_i   level requests, held while stalled
//   cpu_data_o, cpu_stall_o combinational load data and stall
//   sram_*_o                lookup/write port to the tag+data SRAM
//   sram_tag_i/data_i/hit_i SRAM lookup result (victim on miss)
//   mem_*_o                 registered one-cycle line request to memory
//   mem_ack_i, mem_data_i   memory completion and refill line
//
// state         | meaning
// --------------+-------------------------------------------------------
// ST_IDLE       | serve lookups; hits complete in zero cycles
// ST_MISS       | inspect LRU victim, issue write-back or refill request
// ST_WRITEBACK  | wait for ack of dirty-victim write, then request refill
// ST_READMISS   | wait for ack carrying the refill line
// ST_READMISSOK | write refilled line into the LRU way (dirty=0)
module dcache_controller
   import dcache_pkg::*;
(
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic [ADDR_W-1:0]   cpu_addr_i,
   input  logic [WORD_W-1:0]   cpu_data_i,
   input  logic                cpu_MemRead_i,
   input  logic                cpu_MemWrite_i,
   output logic [WORD_W-1:0]   cpu_data_o,
   output logic                cpu_stall_o,
   output logic                sram_enable_o,
   output logic                sram_write_o,
   output logic [IDX_W-1:0]    sram_index_o,
   output logic [TAGF_W-1:0]   sram_tag_o,
   output logic [LINE_W-1:0]   sram_data_o,
   input  logic [TAGF_W-1:0]   sram_tag_i,
   input  logic [LINE_W-1:0]   sram_data_i,
   input  logic                sram_hit_i,
   output logic                mem_enable_o,
   output logic                mem_write_o,
   output logic [ADDR_W-1:0]   mem_addr_o,
   output logic [LINE_W-1:0]   mem_data_o,
   input  logic                mem_ack_i,
   input  logic [LINE_W-1:0]   mem_data_i
);

   state_t                   state_q;
   logic [LINE_W-1:0]        refill_q;
   logic [TAG_W+IDX_W-1:0]   miss_line_q;

   logic                     req;
   logic                     in_idle;
   logic                     store_hit;
   logic                     victim_dirty;
   logic [TAG_W-1:0]         cpu_tag;
   logic [IDX_W-1:0]         cpu_idx;
   logic [TAG_W-1:0]         miss_tag;
   logic [IDX_W-1:0]         miss_idx;
   logic [LINE_W-1:0]        merged_line;
   logic                     unused_bits;

   assign req          = cpu_MemRead_i | cpu_MemWrite_i;
   assign in_idle      = (state_q == ST_IDLE);
   // A simultaneous read+write request is handled as a store.
   assign store_hit    = in_idle & cpu_MemWrite_i & sram_hit_i;
   assign victim_dirty = sram_tag_i[VALID_BIT] & sram_tag_i[DIRTY_BIT];

   assign cpu_tag  = cpu_addr_i[TAG_HI:TAG_LO];
   assign cpu_idx  = cpu_addr_i[IDX_HI:IDX_LO];
   assign miss_tag = miss_line_q[TAG_W+IDX_W-1:IDX_W];
   assign miss_idx = miss_line_q[IDX_W-1:0];

   assign unused_bits = ^cpu_addr_i[WORD_LO-1:0];

   dcache_line_merge u_merge (
      .line_i (sram_data_i),
      .sel_i  (cpu_addr_i[WORD_HI:WORD_LO]),
      .word_i (cpu_data_i),
      .word_o (cpu_data_o),
      .line_o (merged_line)
   );

   // Outside IDLE the SRAM is addressed from the latched miss line, so the
   // refill still lands in the right set if the CPU drops its request.
   always_comb begin
      cpu_stall_o   = 1'b1;
      sram_enable_o = 1'b0;
      sram_write_o  = 1'b0;
      sram_index_o  = miss_idx;
      sram_tag_o    = {1'b1, 1'b0, miss_tag};
      sram_data_o   = refill_q;
      case (state_q)
         ST_IDLE: begin
            cpu_stall_o   = req & ~sram_hit_i;
            sram_enable_o = req;
            sram_index_o  = cpu_idx;
            sram_tag_o    = {1'b1, store_hit, cpu_tag};
            sram_write_o  = store_hit;
            sram_data_o   = merged_line;
         end
         ST_MISS: begin
            sram_enable_o = 1'b1;
         end
         ST_READMISSOK: begin
            // dirty=0 on write selects the LRU way for the fill.
            sram_enable_o = 1'b1;
            sram_write_o  = 1'b1;
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q      <= ST_IDLE;
         mem_enable_o <= 1'b0;
         mem_write_o  <= 1'b0;
         mem_addr_o   <= '0;
         mem_data_o   <= '0;
         refill_q     <= '0;
         miss_line_q  <= '0;
      end else begin
         mem_enable_o <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (req & ~sram_hit_i) begin
                  miss_line_q <= cpu_addr_i[TAG_HI:IDX_LO];
                  state_q     <= ST_MISS;
               end
            end
            ST_MISS: begin
               mem_enable_o <= 1'b1;
               if (victim_dirty) begin
                  mem_write_o <= 1'b1;
                  mem_addr_o  <= line_addr(sram_tag_i[TAG_W-1:0], miss_idx);
                  mem_data_o  <= sram_data_i;
                  state_q     <= ST_WRITEBACK;
               end else begin
                  mem_write_o <= 1'b0;
                  mem_addr_o  <= line_addr(miss_tag, miss_idx);
                  state_q     <= ST_READMISS;
               end
            end
            ST_WRITEBACK: begin
               if (mem_ack_i) begin
                  mem_enable_o <= 1'b1;
                  mem_write_o  <= 1'b0;
                  mem_addr_o   <= line_addr(miss_tag, miss_idx);
                  state_q      <= ST_READMISS;
               end
            end
            ST_READMISS: begin
               if (mem_ack_i) begin
                  refill_q <= mem_data_i;
                  state_q  <= ST_READMISSOK;
               end
            end
            ST_READMISSOK: begin
               state_q <= ST_IDLE;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/dcache_controller.md
Name: dcache_controller

Overview:
Initiator-side controller for the 2-way dcache SRAM (16 sets, 256-bit lines, 25-bit tag field {valid, dirty, tag[22:0]}). It accepts single-word CPU loads and stores and drives the SRAM's combinational lookup and write port. On a miss it runs a write-back/refill sequence against the line-wide data memory and stalls the CPU until the access hits.

Parameters:
ADDR_W, 32, CPU/memory byte address width
LINE_W, 256, cache line width (32 bytes)
IDX_W, 4, set index width (16 sets)
TAG_W, 23, address tag width (ADDR_W-IDX_W-5)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
cpu_addr_i  in  32  byte address: tag[31:9], index[8:5], word[4:2]
cpu_data_i  in  32  store data
cpu_MemRead_i  in  1  load request (level, held while stalled)
cpu_MemWrite_i  in  1  store request (level, held while stalled)
cpu_data_o  out  32  load data, combinational, valid when req & ~stall
cpu_stall_o  out  1  combinational stall
sram_enable_o  out  1  SRAM enable
sram_write_o  out  1  SRAM write strobe
sram_index_o  out  4  SRAM set index
sram_tag_o  out  25  {valid, dirty, tag} to SRAM
sram_data_o  out  256  line to SRAM
sram_tag_i  in  25  on hit: request tag; on miss: LRU victim tag
sram_data_i  in  256  hit line or victim line
sram_hit_i  in  1  combinational hit
mem_enable_o  out  1  one-cycle memory request pulse
mem_write_o  out  1  qualifies mem_enable_o: 1 = line write
mem_addr_o  out  32  line address, [4:0]=0
mem_data_o  out  256  write-back line
mem_ack_i  in  1  one-cycle completion; read data valid in the ack cycle
mem_data_i  in  256  refill line

Behaviour:
- req = MemRead | MemWrite; both high is treated as a write. sram_index_o = addr[8:5]; sram_enable_o = req in IDLE, MISS and READMISSOK.
- States: IDLE, MISS, WRITEBACK, READMISS, READMISSOK. Reset enters IDLE; mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0 (all registered).
- IDLE, hit: cpu_stall_o=0.
  - Load: cpu_data_o = sram_data_i word addr[4:2] (bits 32w+31:32w).
  - Store: sram_write_o=1, sram_tag_o={1,1,tag}, sram_data_o = sram_data_i with word w replaced by cpu_data_i. Zero-cycle penalty.
- IDLE, miss (req & ~hit): stall=1, go to MISS.
- MISS: victim = sram_tag_i/sram_data_i.
  - Victim valid & dirty: next cycle mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 5'b0}, mem_data_o=victim line (latched at transition). Go to WRITEBACK.
  - Otherwise: mem_enable_o=1, mem_write_o=0, mem_addr_o={cpu tag, index, 0}. Go to READMISS.
- WRITEBACK: wait for mem_ack_i. On ack, issue the read pulse for the CPU line and go to READMISS.
- READMISS: wait for mem_ack_i. On ack, latch mem_data_i and go to READMISSOK.
- READMISSOK: one cycle, sram_write_o=1, sram_tag_o={1,0,tag} (dirty=0 tells the SRAM to fill the LRU way), sram_data_o=refill line. Then IDLE, where the access re-looks up and hits. A store is merged on that hit, which sets dirty.
- mem_enable_o is high for exactly one cycle per request. No new request is issued until the matching ack arrives. Ack in IDLE or MISS is ignored.
- Miss latency = memory latency(s) + 3 cycles.
- Stall stays 1 in every non-IDLE state regardless of req.
- Request dropped mid-miss: the sequence still completes (the line is filled), then IDLE.
- Reset at any state: IDLE next cycle, outstanding memory transaction abandoned, later ack ignored.

Decomposition:
- Shared package dcache_pkg:
  - state encoding constants
  - field widths TAG_W, IDX_W, LINE_W
  - tag-field bit positions VALID_BIT=24, DIRTY_BIT=23
  - address slice constants
- Sub-module dcache_line_merge: combinational word select (256→32) and word insert (256+32→256) by word index.

Test Plan:
- Reset, load 0x0000_0004 with memory line word1=0xDEADBEEF -> stall, read pulse addr 0x0000_0000, refill write with tag valid=1/dirty=0, then data_o=0xDEADBEEF, stall falls.
- Load same address again -> stall=0 same cycle, no mem_enable_o.
- Store 0x12345678 to 0x0000_0008 (hit) -> sram_write_o with tag dirty=1, word2 updated, no memory traffic.
- Fill both ways of set 0 (0x0000, 0x0200), dirty one, access 0x0400 -> write-back pulse to the dirty victim line address with the merged line, then read 0x0400, 3-cycle overhead beyond acks.
- Memory ack delayed 10 cycles -> mem_enable_o single pulse, stall held throughout, no duplicate request.
- Assert rst_i in WRITEBACK -> IDLE next cycle, outputs zero, late mem_ack_i ignored, next miss proceeds normally.
